// File: rtl/rv_lsu_pkg.sv
// -----------------------------------------------------------------------------
// rv_lsu_pkg -- shared types for the load/store unit controller.
//   lsu_size_e    : access size encoding carried on req_size_i
//   lsu_state_e   : controller FSM states
//   lsu_req_t     : request fields latched at acceptance
//   is_misaligned : alignment rule applied at acceptance
// -----------------------------------------------------------------------------
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_e;

  typedef struct packed {
    logic        wr;
    lsu_size_e   size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Reserved size is always rejected; halves need an even address, words a
  // 4-byte aligned address.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = (off != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// -----------------------------------------------------------------------------
// rv_lsu_align -- combinational lane handling for the LSU.
//   size_i, unsigned_i, offset_i : access size, zero-extend flag, addr[1:0]
//   ld_word_i  -> ld_data_o      : addressed byte/half extracted and extended
//   st_word_i, wdata_i -> st_word_o : old word with the addressed lane(s)
//                                     replaced by right-aligned store data
// -----------------------------------------------------------------------------
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = 8'h00;
    case (offset_i)
      2'd0: ld_byte = ld_word_i[7:0];
      2'd1: ld_byte = ld_word_i[15:8];
      2'd2: ld_byte = ld_word_i[23:16];
      2'd3: ld_byte = ld_word_i[31:24];
      default: ld_byte = 8'h00;
    endcase
    // Halves are only ever reached with offset 0 or 2.
    ld_half = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    case (size_i)
      SIZE_BYTE: ld_data_o = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_word_o = st_word_i;
    case (size_i)
      SIZE_BYTE: begin
        case (offset_i)
          2'd0: st_word_o[7:0]   = wdata_i[7:0];
          2'd1: st_word_o[15:8]  = wdata_i[7:0];
          2'd2: st_word_o[23:16] = wdata_i[7:0];
          2'd3: st_word_o[31:24] = wdata_i[7:0];
          default: st_word_o = st_word_i;
        endcase
      end
      SIZE_HALF: begin
        if (offset_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else             st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/rv_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// rv_lsu_ctrl -- single-outstanding load/store controller for a word-wide
// data memory with combinational read and clock-edge write.
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o        : request handshake (ready only in IDLE)
//   req_wr_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i : request
//   rsp_valid_o/rsp_ready_i        : response handshake
//   rsp_rdata_o, rsp_err_o         : load data (0 for stores), error flag
//   dmem_addr_o, dmem_wr_o, dmem_wr_data_o, dmem_data_i : memory port
// Sub-word stores are read-modify-write: ACCESS captures the old word,
// WRITE stores the merged word.
// -----------------------------------------------------------------------------
module rv_lsu_ctrl
  import rv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_wr_o,
  output logic [31:0] dmem_wr_data_o,
  input  logic [31:0] dmem_data_i
);

  lsu_state_e  state_q;
  lsu_req_t    req_q;
  logic [31:0] word_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        rsp_valid_q;
  logic        req_ready_q;

  logic [31:0] ld_data;
  logic [31:0] st_word;

  rv_lsu_align u_align (
    .size_i     (req_q.size),
    .unsigned_i (req_q.is_unsigned),
    .offset_i   (req_q.addr[1:0]),
    .ld_word_i  (dmem_data_i),
    .ld_data_o  (ld_data),
    .st_word_i  (word_q),
    .wdata_i    (req_q.wdata),
    .st_word_o  (st_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      word_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_q       <= '{wr:          req_wr_i,
                             size:        lsu_size_e'(req_size_i),
                             is_unsigned: req_unsigned_i,
                             addr:        req_addr_i,
                             wdata:       req_wdata_i};
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            if (is_misaligned(lsu_size_e'(req_size_i), req_addr_i[1:0])) begin
              // Rejected requests never touch memory.
              state_q     <= ST_RESP;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q   <= ST_ACCESS;
              rsp_err_q <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (req_q.wr) begin
            if (req_q.size == SIZE_WORD) begin
              // The write itself happens on this edge (dmem_wr_o decoded below).
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              word_q  <= dmem_data_i;
              state_q <= ST_WRITE;
            end
          end else begin
            rsp_rdata_q <= ld_data;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            // Ready returns one cycle after the handshake, so no request can
            // be accepted in the consuming cycle.
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Write strobe decoded from registered state; data forced to 0 when idle.
  always_comb begin
    dmem_wr_o      = 1'b0;
    dmem_wr_data_o = 32'h0;
    if (state_q == ST_ACCESS && req_q.wr && req_q.size == SIZE_WORD) begin
      dmem_wr_o      = 1'b1;
      dmem_wr_data_o = req_q.wdata;
    end else if (state_q == ST_WRITE) begin
      dmem_wr_o      = 1'b1;
      dmem_wr_data_o = st_word;
    end
  end

  assign dmem_addr_o = {2'b00, req_q.addr[31:2]};
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/rv_lsu_ctrl.md
RV_LSU_CTRL -- requirements
Module: rv_lsu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; every register samples on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1): request handshake from the execute stage.
REQ-004 SHALL have port req_wr_i, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-006 SHALL have port req_unsigned_i, input, 1 bit: zero-extend load data (LBU/LHU).
REQ-007 SHALL have ports req_addr_i (in, 32, byte address) and req_wdata_i (in, 32, store data, right-aligned).
REQ-008 SHALL have ports rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_rdata_o (out, 32) and rsp_err_o (out, 1): response handshake.
REQ-009 SHALL have ports dmem_addr_o (out, 32, word index), dmem_wr_o (out, 1), dmem_wr_data_o (out, 32) and dmem_data_i (in, 32): the word-wide data memory, which has a combinational read and a write on the clock edge.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WRITE and RESP.
REQ-011 SHALL drive req_ready_o = 1 only in IDLE; it SHALL latch all req_* inputs on valid && ready and then leave IDLE.
REQ-012 SHALL detect misalignment at acceptance: half with addr[0]=1; word with addr[1:0]!=0; size 11 in all cases. On misalignment it SHALL go IDLE->RESP with rsp_err_o=1, rsp_rdata_o=0 and no memory access.
REQ-013 SHALL drive dmem_addr_o = {2'b00, addr[31:2]} from the latched address.
REQ-014 SHALL, for a load in ACCESS, capture dmem_data_i, extract the lane selected by addr[1:0], sign-extend (or zero-extend if unsigned), then go to RESP.
REQ-015 SHALL, for a word store in ACCESS, assert dmem_wr_o=1 with dmem_wr_data_o=wdata, then go to RESP.
REQ-016 SHALL, for a byte or half store in ACCESS, capture dmem_data_i and go to WRITE.
REQ-017 SHALL, in WRITE, assert dmem_wr_o=1 with the captured word where only the addressed byte or half is replaced by wdata[7:0] or wdata[15:0], then go to RESP.
REQ-018 SHALL assert dmem_wr_o only in the cycles defined by REQ-015 and REQ-017, for exactly one cycle per store; dmem_wr_data_o SHALL be 0 whenever dmem_wr_o=0.
REQ-019 SHALL, in RESP, hold rsp_valid_o=1 with rsp_rdata_o and rsp_err_o stable until rsp_ready_i=1, then return to IDLE. rsp_rdata_o SHALL be 0 for stores.
REQ-020 SHALL meet these latencies, with acceptance in cycle T: error response in T+1; load and word store response in T+2; sub-word store response in T+3.
REQ-021 SHALL NOT accept a new request in the cycle a response is consumed (ready rises the following cycle), giving at most one outstanding request.
REQ-022 SHALL keep rsp_valid_o=0 whenever it is not in RESP.

Reset
REQ-023 SHALL, with reset=1 at a clock edge, enter IDLE and clear the latched request, captured word, rsp_rdata_o and rsp_err_o to 0.
REQ-024 SHALL, after reset, present req_ready_o=1, rsp_valid_o=0, dmem_wr_o=0, dmem_wr_data_o=0 and dmem_addr_o=0.
REQ-025 SHALL, when reset is asserted in ACCESS or WRITE, abort the operation; no dmem_wr_o pulse SHALL occur from that edge onward, and the pending response SHALL be dropped.

Structure
REQ-026 SHALL take its size encoding (enum) and FSM state enum from a shared package, rv_lsu_pkg.
REQ-027 SHALL place lane extraction with sign extension and store merging in a combinational sub-module, rv_lsu_align.
REQ-028 SHALL be sized at 150-300 lines of RTL in total.

Verification
REQ-029 SHALL cover a word load: mem[4]=0x8765_4321, LW addr 0x10 -> dmem_addr_o=4, rsp at T+2, rdata 0x8765_4321, err 0.
REQ-030 SHALL cover byte loads with signedness: mem[4]=0x80FF_7F01, LB addr 0x13 -> 0xFFFF_FF80; LBU addr 0x13 -> 0x0000_0080; LB addr 0x11 -> 0x0000_007F.
REQ-031 SHALL cover read-modify-write: mem[2]=0x1122_3344, SH addr 0x0A, wdata 0xABCD_BEEF -> one dmem_wr_o pulse in T+2, mem[2]=0xBEEF_3344, rsp at T+3.
REQ-032 SHALL cover misaligned and reserved requests: LW addr 0x06; also size 11 -> rsp_err_o=1 at T+1, dmem_wr_o never asserted, memory unchanged.
REQ-033 SHALL cover backpressure: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data held stable, req_ready_o=0 throughout, req_ready_o=1 the cycle after the handshake.
REQ-034 SHALL cover reset during a sub-word store: reset asserted in ACCESS of SB addr 0x21 -> no write, mem[8] unchanged, IDLE with req_ready_o=1 the next cycle.
